// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the WISC instruction-fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] BUBBLE_INSTR     = 16'h0000;
  localparam logic [3:0]  OPC_HLT          = 4'hF;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [15:0] PC_STEP          = 16'h0002;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.instr = BUBBLE_INSTR;
    b.pc2   = 16'h0000;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_unit_addsub.sv
// 16-bit two's-complement adder/subtractor; wraps silently on overflow.
module addsub_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        is_sub_i,
  output logic [15:0] sum_o
);

  logic [15:0] b_eff;

  assign b_eff = b_i ^ {16{is_sub_i}};
  assign sum_o = a_i + b_eff + {15'd0, is_sub_i};

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, I-cache port control and IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc2,
  output logic        ifid_valid,
  output logic        fetch_busy,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  miss_addr_q, miss_addr_d;
  ifid_t        ifid_q, ifid_d;
  logic [15:0]  pc_plus2;

  addsub_16bit u_pc_inc (
    .a_i      (pc_q),
    .b_i      (PC_STEP),
    .is_sub_i (1'b0),
    .sum_o    (pc_plus2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      miss_addr_q <= RESET_PC;
      ifid_q      <= ifid_bubble();
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      ifid_q      <= ifid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    ifid_d      = ifid_q;

    if (redirect_en) begin
      // Wrong-path word is squashed even under stall; an outstanding miss
      // must still be drained before the target address can be presented.
      pc_d   = redirect_pc;
      ifid_d = ifid_bubble();
      if ((state_q == ST_MISS || state_q == ST_DRAIN) && !imem_rdy) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (imem_rdy) begin
            if (!stall) begin
              ifid_d.instr = imem_data;
              ifid_d.pc2   = pc_plus2;
              ifid_d.valid = 1'b1;
              pc_d         = pc_plus2;
              if (imem_data[15:12] == OPC_HLT) begin
                state_d = ST_HALT;
              end
            end
          end else begin
            miss_addr_d = pc_q;
            state_d     = ST_MISS;
            if (!stall) begin
              ifid_d = ifid_bubble();
            end
          end
        end
        ST_MISS, ST_DRAIN: begin
          // The line becoming ready is only a signal to return to RUN;
          // the word itself is refetched there as a hit (or dropped for DRAIN).
          if (!stall) begin
            ifid_d = ifid_bubble();
          end
          if (imem_rdy) begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          if (!stall) begin
            ifid_d = ifid_bubble();
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign imem_req   = (state_q != ST_HALT);
  assign imem_addr  = (state_q == ST_MISS || state_q == ST_DRAIN) ? miss_addr_q : pc_q;
  assign fetch_busy = (state_q == ST_MISS || state_q == ST_DRAIN);
  assign halted     = (state_q == ST_HALT);
  assign pc         = pc_q;
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc2   = ifid_q.pc2;
  assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each cycle's expected post-edge state is queued, then compared.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_en, imem_rdy;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_req, ifid_valid, fetch_busy, halted;
  logic [15:0] imem_addr, pc, ifid_instr, ifid_pc2;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
    logic        halted;
    logic        busy;
    logic        req;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory image: HLT at 0x0020, otherwise a tagged copy of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0020) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  assign imem_data = imem_rdy ? mem_word(imem_addr) : 16'hDEAD;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc2    (ifid_pc2),
    .ifid_valid  (ifid_valid),
    .fetch_busy  (fetch_busy),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, got, want);
    end
  endtask

  int cyc_n = 0;

  task automatic cyc(input logic r, input logic stl, input logic red, input logic [15:0] rpc,
                     input logic rdy, input logic [15:0] e_pc, input logic [15:0] e_instr,
                     input logic [15:0] e_pc2, input logic e_v, input logic e_h,
                     input logic e_b, input logic e_req, input logic [15:0] e_addr);
    exp_t e, got;
    rst = r; stall = stl; redirect_en = red; redirect_pc = rpc; imem_rdy = rdy;
    e = '{pc: e_pc, instr: e_instr, pc2: e_pc2, valid: e_v, halted: e_h,
          busy: e_b, req: e_req, addr: e_addr};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    cyc_n++;
    $display("[TB] cycle %0d rst=%0b stall=%0b redir=%0b rdy=%0b -> pc=%04h instr=%04h pc2=%04h v=%0b h=%0b busy=%0b req=%0b addr=%04h",
             cyc_n, r, stl, red, rdy, pc, ifid_instr, ifid_pc2, ifid_valid, halted, fetch_busy, imem_req, imem_addr);
    chk("pc",         pc,                got.pc);
    chk("ifid_instr", ifid_instr,        got.instr);
    chk("ifid_pc2",   ifid_pc2,          got.pc2);
    chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, got.valid});
    chk("halted",     {15'd0, halted},     {15'd0, got.halted});
    chk("fetch_busy", {15'd0, fetch_busy}, {15'd0, got.busy});
    chk("imem_req",   {15'd0, imem_req},   {15'd0, got.req});
    chk("imem_addr",  imem_addr,         got.addr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0; imem_rdy = 1'b1;
    //  rst stl red rpc       rdy  pc       instr    pc2      v  h  b  req addr
    cyc(1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000);
    // sequential hits
    cyc(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h1000, 16'h0002, 1, 0, 0, 1, 16'h0002);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0004, 16'h1002, 16'h0004, 1, 0, 0, 1, 16'h0004);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0006, 16'h1004, 16'h0006, 1, 0, 0, 1, 16'h0006);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0008, 16'h1006, 16'h0008, 1, 0, 0, 1, 16'h0008);
    // redirect from RUN
    cyc(0, 0, 1, 16'h0040, 1, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0040);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0042, 16'h1040, 16'h0042, 1, 0, 0, 1, 16'h0042);
    // miss for 3 cycles at 0x0010
    cyc(0, 0, 1, 16'h0010, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0010);
    cyc(0, 0, 0, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0010);
    cyc(0, 0, 0, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0010);
    cyc(0, 0, 0, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0010);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0010);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0012, 16'h1010, 16'h0012, 1, 0, 0, 1, 16'h0012);
    // redirect during miss -> DRAIN
    cyc(0, 0, 1, 16'h0010, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0010);
    cyc(0, 0, 0, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0010);
    cyc(0, 0, 1, 16'h0080, 0, 16'h0080, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0010);
    cyc(0, 0, 0, 16'h0000, 0, 16'h0080, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0010);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0080, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0080);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0082, 16'h1080, 16'h0082, 1, 0, 0, 1, 16'h0082);
    // HLT at 0x0020, then redirect out of HALT
    cyc(0, 0, 1, 16'h0020, 1, 16'h0020, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0020);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0022, 16'hF000, 16'h0022, 1, 1, 0, 0, 16'h0022);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0022, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0022);
    cyc(0, 0, 1, 16'h0100, 1, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0100);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0102, 16'h1100, 16'h0102, 1, 0, 0, 1, 16'h0102);
    // stall holds PC and IF/ID
    cyc(0, 1, 0, 16'h0000, 1, 16'h0102, 16'h1100, 16'h0102, 1, 0, 0, 1, 16'h0102);
    cyc(0, 1, 0, 16'h0000, 1, 16'h0102, 16'h1100, 16'h0102, 1, 0, 0, 1, 16'h0102);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0104, 16'h1102, 16'h0104, 1, 0, 0, 1, 16'h0104);
    // redirect wins over stall
    cyc(0, 1, 1, 16'h0200, 1, 16'h0200, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0200);
    // PC wrap 0xFFFE -> 0x0000
    cyc(0, 0, 1, 16'hFFFE, 1, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hFFFE);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0000, 16'h1FFE, 16'h0000, 1, 0, 0, 1, 16'h0000);
    // reset during MISS
    cyc(0, 0, 1, 16'h0030, 1, 16'h0030, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0030);
    cyc(0, 0, 0, 16'h0000, 0, 16'h0030, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0030);
    cyc(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h1000, 16'h0002, 1, 0, 0, 1, 16'h0002);
    // miss under stall keeps IF/ID, then bubbles on return
    cyc(0, 1, 0, 16'h0000, 0, 16'h0002, 16'h1000, 16'h0002, 1, 0, 1, 1, 16'h0002);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0002);
    cyc(0, 0, 0, 16'h0000, 1, 16'h0004, 16'h1002, 16'h0004, 1, 0, 0, 1, 16'h0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
